vc_merge_arbiter: RTL and testbench

Downstream stage of the transaction-layer round-robin splitter: drains the four per-channel FIFOs that the splitter fills and merges their words into a single output FIFO. Each cycle it selects at most one non-empty channel in round-robin order, pops it, and pushes the returned word two cycles later. New pops are held off on output back-pressure and outside the ACTIVE state.

---
 rtl/vc_merge_arbiter.sv | 139 +++++++++++++
 tb/tb_vc_merge_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_merge_arbiter.sv
// Merges four channel FIFOs into one output FIFO: one pop per cycle, push two cycles later.
// Define VC_ARB_STRICT_PRIO_EN for fixed lowest-index priority instead of round robin.
module vc_merge_arbiter #(
  parameter int unsigned DATA_W = 12
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic [3:0]        state,
  input  logic              empty_0,
  input  logic              empty_1,
  input  logic              empty_2,
  input  logic              empty_3,
  input  logic [DATA_W-1:0] data_in_0,
  input  logic [DATA_W-1:0] data_in_1,
  input  logic [DATA_W-1:0] data_in_2,
  input  logic [DATA_W-1:0] data_in_3,
  input  logic              almost_full_out,
  output logic              pop_0,
  output logic              pop_1,
  output logic              pop_2,
  output logic              pop_3,
  output logic              push_out,
  output logic [DATA_W-1:0] data_out,
  output logic              idle
);

  localparam int unsigned NCH   = 4;
  localparam int unsigned IDX_W = 2;

  localparam logic [3:0] ST_RESET  = 4'b0001;
  localparam logic [3:0] ST_INIT   = 4'b0010;
  localparam logic [3:0] ST_IDLE   = 4'b0100;
  localparam logic [3:0] ST_ACTIVE = 4'b1000;

  logic [NCH-1:0]    pop_q, pop_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  sel1_q, sel1_d;
  logic              v1_q, v1_d;
  logic              push_q, push_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              idle_q, idle_d;

  logic [NCH-1:0]    eligible;
  logic              issue;
  logic              grant_v;
  logic [IDX_W-1:0]  grant_idx;
  logic [IDX_W-1:0]  cand;
  logic [DATA_W-1:0] data_sel;

  // Arbitration, pipeline advance and idle computation
  always_comb begin
    pop_d      = '0;
    rr_ptr_d   = rr_ptr_q;
    sel1_d     = '0;
    v1_d       = 1'b0;
    push_d     = 1'b0;
    data_out_d = data_out_q;
    idle_d     = 1'b1;
    grant_v    = 1'b0;
    grant_idx  = '0;
    cand       = '0;
    data_sel   = '0;

    // A channel being popped right now still looks non-empty, so it is masked out
    eligible = ~{empty_3, empty_2, empty_1, empty_0} & ~pop_q;
    issue    = (state == ST_ACTIVE) && !almost_full_out;

`ifdef VC_ARB_STRICT_PRIO_EN
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        grant_v   = 1'b1;
        grant_idx = IDX_W'(i);
      end
    end
`else
    for (int unsigned i = 1; i <= NCH; i++) begin
      cand = rr_ptr_q + IDX_W'(i);
      if (!grant_v && eligible[cand]) begin
        grant_v   = 1'b1;
        grant_idx = cand;
      end
    end
`endif

    if (issue && grant_v) begin
      pop_d = NCH'(1) << grant_idx;
`ifndef VC_ARB_STRICT_PRIO_EN
      rr_ptr_d = grant_idx;
`endif
    end

    v1_d = |pop_q;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (pop_q[i]) sel1_d = IDX_W'(i);
    end

    case (sel1_q)
      2'd0:    data_sel = data_in_0;
      2'd1:    data_sel = data_in_1;
      2'd2:    data_sel = data_in_2;
      default: data_sel = data_in_3;
    endcase

    push_d = v1_q;
    if (v1_q) data_out_d = data_sel;

    idle_d = ~(|pop_d | v1_d | push_d);
  end

  // State registers; link RESET state clears exactly like reset_L
  always_ff @(posedge clk) begin
    if (!reset_L || (state == ST_RESET)) begin
      pop_q      <= '0;
      rr_ptr_q   <= IDX_W'(NCH - 1);
      sel1_q     <= '0;
      v1_q       <= 1'b0;
      push_q     <= 1'b0;
      data_out_q <= '0;
      idle_q     <= 1'b1;
    end else begin
      pop_q      <= pop_d;
      rr_ptr_q   <= rr_ptr_d;
      sel1_q     <= sel1_d;
      v1_q       <= v1_d;
      push_q     <= push_d;
      data_out_q <= data_out_d;
      idle_q     <= idle_d;
    end
  end

  assign pop_0    = pop_q[0];
  assign pop_1    = pop_q[1];
  assign pop_2    = pop_q[2];
  assign pop_3    = pop_q[3];
  assign push_out = push_q;
  assign data_out = data_out_q;
  assign idle     = idle_q;

endmodule

// File: tb/tb_vc_merge_arbiter.sv
// Scoreboard bench for vc_merge_arbiter: FIFO environment, reference arbiter model, push monitor.
module tb_vc_merge_arbiter;

  localparam int unsigned DATA_W = 12;
  localparam int          DEPTH  = 256;
  localparam logic [3:0]  S_RESET  = 4'b0001;
  localparam logic [3:0]  S_INIT   = 4'b0010;
  localparam logic [3:0]  S_IDLE   = 4'b0100;
  localparam logic [3:0]  S_ACTIVE = 4'b1000;

  logic              clk;
  logic              reset_L;
  logic [3:0]        state;
  logic              empty_0, empty_1, empty_2, empty_3;
  logic [DATA_W-1:0] data_in_0, data_in_1, data_in_2, data_in_3;
  logic              almost_full_out;
  logic              pop_0, pop_1, pop_2, pop_3;
  logic              push_out;
  logic [DATA_W-1:0] data_out;
  logic              idle;

  vc_merge_arbiter #(.DATA_W(DATA_W)) dut (
    .clk(clk), .reset_L(reset_L), .state(state),
    .empty_0(empty_0), .empty_1(empty_1), .empty_2(empty_2), .empty_3(empty_3),
    .data_in_0(data_in_0), .data_in_1(data_in_1), .data_in_2(data_in_2), .data_in_3(data_in_3),
    .almost_full_out(almost_full_out),
    .pop_0(pop_0), .pop_1(pop_1), .pop_2(pop_2), .pop_3(pop_3),
    .push_out(push_out), .data_out(data_out), .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  // Words ever loaded per channel (written only by the stimulus process)
  logic [DATA_W-1:0] ld_data [4][DEPTH];
  int                ld_total [4] = '{0, 0, 0, 0};

  // Channel FIFO environment: registered read port, pops on the edge ending a pop cycle
  int                e_rd [4] = '{0, 0, 0, 0};
  logic [DATA_W-1:0] din  [4] = '{default: '0};
  logic [3:0]        pop_s = '0;

  assign empty_0 = (e_rd[0] >= ld_total[0]);
  assign empty_1 = (e_rd[1] >= ld_total[1]);
  assign empty_2 = (e_rd[2] >= ld_total[2]);
  assign empty_3 = (e_rd[3] >= ld_total[3]);
  assign data_in_0 = din[0];
  assign data_in_1 = din[1];
  assign data_in_2 = din[2];
  assign data_in_3 = din[3];

  always @(negedge clk) pop_s = {pop_3, pop_2, pop_1, pop_0};

  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 4; k++) begin
      if (pop_s[k] === 1'b1) begin
        n_vec++;
        if (e_rd[k] >= ld_total[k]) begin
          n_err++;
          $display("FAIL underflow: pop of ch%0d got empty fifo, required non-empty (cycle %0d)", k, cyc);
        end else begin
          din[k] = ld_data[k][e_rd[k]];
          e_rd[k]++;
        end
      end
    end
  end

  // Scoreboard entries: expected word, cycle it must be pushed, clear generation
  typedef struct {
    logic [DATA_W-1:0] data;
    int                cyc;
    int                gen;
  } sb_t;
  sb_t sb[$];
  int  flush_gen = 0;

  // Reference model: evaluated mid-cycle, predicts the pop of the next cycle
  int   cur_pop   = -1;
  int   rr        = 3;
  logic exp_idle  = 1'b1;
  int   m_rd [4]  = '{0, 0, 0, 0};
  int   last_push = -10;

  always @(negedge clk) begin : model
    logic [3:0] act_pop;
    logic [3:0] exp_pop;
    logic       ok_issue;
    int         g;
    int         c;
    act_pop = {pop_3, pop_2, pop_1, pop_0};
    exp_pop = (cur_pop >= 0) ? (4'(1) << cur_pop) : 4'd0;
    n_vec++;
    if (act_pop !== exp_pop) begin
      n_err++;
      $display("FAIL pop cycle %0d: got %b required %b", cyc, act_pop, exp_pop);
    end
    n_vec++;
    if (idle !== exp_idle) begin
      n_err++;
      $display("FAIL idle cycle %0d: got %b required %b", cyc, idle, exp_idle);
    end

    g = -1;
`ifdef VC_ARB_STRICT_PRIO_EN
    for (int k = 0; k < 4; k++)
      if (g < 0 && m_rd[k] < ld_total[k] && k != cur_pop) g = k;
`else
    for (int j = 1; j <= 4; j++) begin
      c = (rr + j) % 4;
      if (g < 0 && m_rd[c] < ld_total[c] && c != cur_pop) g = c;
    end
`endif
    ok_issue = (state == S_ACTIVE) && !almost_full_out;

    if (cur_pop >= 0 && m_rd[cur_pop] < ld_total[cur_pop]) begin
      sb.push_back('{ld_data[cur_pop][m_rd[cur_pop]], cyc + 2, flush_gen});
      m_rd[cur_pop]++;
      last_push = cyc + 2;
    end

    if (!reset_L || state == S_RESET) begin
      flush_gen++;
      cur_pop   = -1;
      rr        = 3;
      exp_idle  = 1'b1;
      last_push = -10;
    end else begin
      cur_pop  = ok_issue ? g : -1;
      if (cur_pop >= 0) rr = cur_pop;
      exp_idle = (cur_pop < 0) && (last_push < cyc + 1);
    end
  end

  // Output monitor: every push must match the oldest live expectation and its cycle
  always @(posedge clk) begin : monitor
    sb_t e;
    #3;
    while (sb.size() > 0 && sb[0].gen != flush_gen) void'(sb.pop_front());
    if (push_out !== 1'b0) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL push cycle %0d: got push_out=%b data %h, required no push", cyc, push_out, data_out);
      end else begin
        e = sb.pop_front();
        if (push_out !== 1'b1 || data_out !== e.data || cyc != e.cyc) begin
          n_err++;
          $display("FAIL push cycle %0d: got data %h, required %h at cycle %0d", cyc, data_out, e.data, e.cyc);
        end
      end
    end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
      n_vec++;
      n_err++;
      e = sb.pop_front();
      $display("FAIL push cycle %0d: got no push, required data %h", cyc, e.data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input int k, input logic [DATA_W-1:0] w);
    if (ld_total[k] < DEPTH) begin
      ld_data[k][ld_total[k]] = w;
      ld_total[k]++;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic wait_pop(input int k);
    logic [3:0] p;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      p = {pop_3, pop_2, pop_1, pop_0};
      if (p[k] === 1'b1) seen = 1'b1;
    end
    chk("wait_pop_timeout", 32'(seen), 32'd1);
  endtask

  initial begin
    reset_L = 1'b0;
    state = S_ACTIVE;
    almost_full_out = 1'b0;
    for (int r = 0; r < 2; r++) begin
      load(0, 12'h0A0); load(1, 12'h1B1); load(2, 12'h2C2); load(3, 12'h3D3);
    end
    repeat (2) tick();
    chk("clear_pops", 32'({pop_3, pop_2, pop_1, pop_0}), 32'd0);
    chk("clear_push", 32'(push_out), 32'd0);
    chk("clear_data", 32'(data_out), 32'h000);
    chk("clear_idle", 32'(idle), 32'd1);
    reset_L = 1'b1;
    repeat (14) tick();

    // Single channel: pops alternate with gaps
    load(2, 12'h5A0); load(2, 12'h5A1); load(2, 12'h5A2);
    repeat (12) tick();

    // Back-pressure while streaming
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 4; i++) load(k, DATA_W'($urandom));
    repeat (3) tick();
    almost_full_out = 1'b1;
    repeat (4) tick();
    almost_full_out = 1'b0;
    repeat (20) tick();

    // ACTIVE -> IDLE right after a pop: the word drains
    load(1, 12'h7E1); load(1, 12'h7E2);
    wait_pop(1);
    tick();
    state = S_IDLE;
    repeat (4) tick();
    chk("idle_after_drain", 32'(idle), 32'd1);
    state = S_ACTIVE;
    repeat (6) tick();

    // ACTIVE -> RESET mid-flight: the word is dropped
    load(3, 12'h9C3);
    wait_pop(3);
    tick();
    state = S_RESET;
    tick();
    chk("reset_drop_push", 32'(push_out), 32'd0);
    state = S_ACTIVE;
    repeat (4) tick();

    // Channels 0 and 3 competing
    for (int i = 0; i < 3; i++) begin
      load(0, 12'hA00 + 12'(i)); load(3, 12'hD30 + 12'(i));
    end
    repeat (12) tick();

    // Randomized traffic, back-pressure and link-state changes
    for (int n = 0; n < 2000; n++) begin
      for (int k = 0; k < 4; k++)
        if ($urandom_range(0, 12 + 4 * k) == 0) load(k, DATA_W'($urandom));
      almost_full_out = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 9))
          0:       state = S_RESET;
          1:       state = S_INIT;
          2, 3:    state = S_IDLE;
          default: state = S_ACTIVE;
        endcase
      end
      reset_L = ($urandom_range(0, 299) != 0);
      tick();
    end

    state = S_ACTIVE;
    almost_full_out = 1'b0;
    reset_L = 1'b1;
    repeat (200) tick();
    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    chk("final_idle", 32'(idle), 32'd1);
    for (int k = 0; k < 4; k++) chk("final_drained", 32'(e_rd[k]), 32'(ld_total[k]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
